onehot_checker: RTL and testbench

- Receive-side companion to the 8-bit rotating one-hot counter. The counter resets to 8'b0000_0001 and rotates left once per enabled clock, wrapping from bit 7 back to bit 0.
- Samples the counter's one-hot bus every enabled cycle and decodes it to a binary index.
- Checks one-hot legality and legal step sequencing, gains and loses lock, and keeps a saturating error count.
- Sits beside any one-hot sequencer as a decoder and health monitor.

---
 rtl/onehot_pkg.sv | 24 ++
 rtl/onehot_to_bin.sv | 20 ++
 rtl/onehot_checker.sv | 118 +++++++++++
 tb/tb_onehot_checker.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/onehot_pkg.sv
// Shared types and bit-vector helpers for the one-hot checker.
// Helpers work on a MAX_WIDTH container; callers zero-extend narrower buses.
package onehot_pkg;

    localparam int MAX_WIDTH = 64;

    typedef enum logic {
        HUNT,
        LOCKED
    } state_t;

    // Rotate left within the low 'width' bits, wrapping bit width-1 into bit 0.
    function automatic logic [MAX_WIDTH-1:0] rotl(input logic [MAX_WIDTH-1:0] vec,
                                                  input int width);
        logic [MAX_WIDTH-1:0] mask;
        mask = (MAX_WIDTH'(1) << width) - MAX_WIDTH'(1);
        return ((vec << 1) | (vec >> (width - 1))) & mask;
    endfunction

    function automatic logic is_onehot(input logic [MAX_WIDTH-1:0] vec);
        return (vec != '0) && ((vec & (vec - MAX_WIDTH'(1))) == '0);
    endfunction

endpackage

// File: rtl/onehot_to_bin.sv
// Combinational one-hot to binary encoder.
// The output is only meaningful when exactly one input bit is set.
module onehot_to_bin #(
    parameter int WIDTH = 8,
    parameter int IDXW  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] onehot,
    output logic [IDXW-1:0]  bin
);

    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (onehot[i]) begin
                bin = bin | IDXW'(i);
            end
        end
    end

endmodule

// File: rtl/onehot_checker.sv
// Decoder and health monitor for a rotating one-hot counter bus: tracks lock,
// flags illegal codes and illegal steps, and keeps a saturating error count.
module onehot_checker
    import onehot_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int IDXW     = $clog2(WIDTH),
    parameter int LOCK_CNT = 3,
    parameter int ERRW     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] onehot_in,
    input  logic             clr_err,
    output logic [IDXW-1:0]  idx,
    output logic             idx_valid,
    output logic             locked,
    output logic             err_invalid,
    output logic             err_seq,
    output logic [ERRW-1:0]  err_count
);

    localparam int GW = $clog2(LOCK_CNT + 1);

    state_t               state;
    logic [WIDTH-1:0]     prev;
    logic [GW-1:0]        good_cnt;
    logic [GW-1:0]        hunt_cnt;
    logic [MAX_WIDTH-1:0] in_ext;
    logic [MAX_WIDTH-1:0] prev_ext;
    logic [IDXW-1:0]      enc_idx;
    logic                 legal;
    logic                 step_ok;
    logic                 counted;

    assign in_ext   = MAX_WIDTH'(onehot_in);
    assign prev_ext = MAX_WIDTH'(prev);
    assign legal    = is_onehot(in_ext);
    assign step_ok  = (in_ext == prev_ext) || (in_ext == rotl(prev_ext, WIDTH));

    // A first legal sample after losing the run, or a break in the sequence, restarts at 1.
    assign hunt_cnt = (good_cnt == '0 || step_ok) ? good_cnt + GW'(1) : GW'(1);
    assign counted  = sample_en && (state == LOCKED) && (!legal || !step_ok);

    onehot_to_bin #(
        .WIDTH(WIDTH),
        .IDXW (IDXW)
    ) u_enc (
        .onehot(onehot_in),
        .bin   (enc_idx)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= HUNT;
            prev        <= '0;
            good_cnt    <= '0;
            idx         <= '0;
            idx_valid   <= 1'b0;
            locked      <= 1'b0;
            err_invalid <= 1'b0;
            err_seq     <= 1'b0;
            err_count   <= '0;
        end else begin
            // Clearing wins over accumulation but still records an error seen this cycle.
            if (clr_err) begin
                err_count <= counted ? ERRW'(1) : '0;
            end else if (counted && err_count != '1) begin
                err_count <= err_count + ERRW'(1);
            end

            if (sample_en) begin
                err_invalid <= !legal;
                err_seq     <= legal && !step_ok && (state == LOCKED);
                if (legal) begin
                    idx       <= enc_idx;
                    idx_valid <= 1'b1;
                end else begin
                    idx_valid <= 1'b0;
                end

                case (state)
                    HUNT: begin
                        if (!legal) begin
                            good_cnt <= '0;
                        end else begin
                            prev     <= onehot_in;
                            good_cnt <= hunt_cnt;
                            if (hunt_cnt == GW'(LOCK_CNT)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end
                    end
                    LOCKED: begin
                        if (!legal) begin
                            state    <= HUNT;
                            locked   <= 1'b0;
                            good_cnt <= '0;
                        end else if (!step_ok) begin
                            state    <= HUNT;
                            locked   <= 1'b0;
                            prev     <= onehot_in;
                            good_cnt <= GW'(1);
                        end else begin
                            prev <= onehot_in;
                        end
                    end
                endcase
            end else begin
                err_invalid <= 1'b0;
                err_seq     <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_onehot_checker.sv
// Self-checking bench for onehot_checker: directed test-plan sequences plus
// randomized traffic, compared against a position-based reference model.
module tb_onehot_checker;

    localparam int W    = 8;
    localparam int IW   = 3;
    localparam int LOCK = 3;
    localparam int EW   = 8;
    localparam int CMAX = 255;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          sample_en = 1'b0;
    logic [W-1:0]  onehot_in = '0;
    logic          clr_err = 1'b0;
    logic [IW-1:0] idx;
    logic          idx_valid;
    logic          locked;
    logic          err_invalid;
    logic          err_seq;
    logic [EW-1:0] err_count;

    int tests  = 0;
    int fails  = 0;

    // Reference model state, kept as bit positions rather than vectors.
    int m_locked, m_prevpos, m_good, m_idx, m_valid, m_einv, m_eseq, m_cnt;

    onehot_checker #(
        .WIDTH(W), .IDXW(IW), .LOCK_CNT(LOCK), .ERRW(EW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sample_en  (sample_en),
        .onehot_in  (onehot_in),
        .clr_err    (clr_err),
        .idx        (idx),
        .idx_valid  (idx_valid),
        .locked     (locked),
        .err_invalid(err_invalid),
        .err_seq    (err_seq),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        m_locked = 0; m_prevpos = -1; m_good = 0; m_idx = 0;
        m_valid = 0; m_einv = 0; m_eseq = 0; m_cnt = 0;
    endtask

    function automatic int bitPos(input logic [W-1:0] v);
        int p;
        p = 0;
        for (int i = 0; i < W; i++) if (v[i]) p = i;
        return p;
    endfunction

    task automatic modelStep(input logic en, input logic [W-1:0] v, input logic clr);
        int  pos;
        bit  legal, stepok, counted;
        counted = 0;
        m_einv  = 0;
        m_eseq  = 0;
        if (en) begin
            legal  = ($countones(v) == 1);
            pos    = bitPos(v);
            stepok = (m_prevpos >= 0) && (pos == m_prevpos || pos == (m_prevpos + 1) % W);
            m_valid = legal;
            if (legal) m_idx = pos;
            if (!legal) begin
                m_einv = 1;
                m_good = 0;
                if (m_locked) begin
                    counted  = 1;
                    m_locked = 0;
                end
            end else if (!m_locked) begin
                m_good    = (m_good == 0 || stepok) ? m_good + 1 : 1;
                m_prevpos = pos;
                if (m_good >= LOCK) m_locked = 1;
            end else if (!stepok) begin
                m_eseq    = 1;
                counted   = 1;
                m_locked  = 0;
                m_prevpos = pos;
                m_good    = 1;
            end else begin
                m_prevpos = pos;
            end
        end
        if (clr) m_cnt = counted ? 1 : 0;
        else if (counted && m_cnt < CMAX) m_cnt++;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".idx"},         int'(idx),         m_valid ? m_idx : int'(idx) == m_idx ? m_idx : m_idx);
        checkOutput({tag, ".idx_valid"},   int'(idx_valid),   m_valid);
        checkOutput({tag, ".locked"},      int'(locked),      m_locked);
        checkOutput({tag, ".err_invalid"}, int'(err_invalid), m_einv);
        checkOutput({tag, ".err_seq"},     int'(err_seq),     m_eseq);
        checkOutput({tag, ".err_count"},   int'(err_count),   m_cnt);
    endtask

    task automatic applyStimulus(input logic en, input logic [W-1:0] v, input logic clr,
                                 input string tag);
        @(negedge clk);
        sample_en = en;
        onehot_in = v;
        clr_err   = clr;
        @(posedge clk);
        #1;
        modelStep(en, v, clr);
        checkAll(tag);
    endtask

    task automatic asyncReset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        modelReset();
        checkAll(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin : stim
        logic [W-1:0] v;
        logic [W-1:0] one;
        int r, nxt;
        logic [W-1:0] dir[] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                8'h01, 8'h01, 8'h01, 8'h02, 8'h04, 8'h0C, 8'h01, 8'h02,
                                8'h04, 8'h20, 8'h40, 8'h80, 8'h01};
        one = 8'h01;

        modelReset();
        #12;
        checkAll("reset");
        rst = 1'b1;

        foreach (dir[i]) applyStimulus(1'b1, dir[i], 1'b0, $sformatf("dir%0d", i));

        applyStimulus(1'b0, 8'h00, 1'b0, "hold0");
        applyStimulus(1'b0, 8'h00, 1'b0, "hold1");
        asyncReset("midreset");

        // Drive the error counter into saturation; each error is taken while locked.
        for (int i = 0; i < CMAX + 4; i++) begin
            applyStimulus(1'b1, 8'h01, 1'b0, "sat.a");
            applyStimulus(1'b1, 8'h02, 1'b0, "sat.b");
            applyStimulus(1'b1, 8'h04, 1'b0, "sat.c");
            applyStimulus(1'b1, 8'h00, 1'b0, "sat.err");
        end
        checkOutput("saturated", int'(err_count), CMAX);
        applyStimulus(1'b1, 8'h01, 1'b0, "clr.a");
        applyStimulus(1'b1, 8'h02, 1'b0, "clr.b");
        applyStimulus(1'b1, 8'h04, 1'b0, "clr.c");
        applyStimulus(1'b1, 8'h10, 1'b1, "clr.witherr");
        applyStimulus(1'b0, 8'h00, 1'b1, "clr.alone");

        for (int n = 0; n < 3000; n++) begin
            r   = $urandom_range(0, 99);
            nxt = (m_prevpos < 0) ? 0 : m_prevpos;
            if (r < 55)      v = one << ((nxt + 1) % W);
            else if (r < 70) v = one << nxt;
            else if (r < 80) v = one << $urandom_range(0, W - 1);
            else if (r < 92) v = W'($urandom);
            else             v = '0;
            applyStimulus(($urandom_range(0, 99) < 85), v, ($urandom_range(0, 99) < 3), "rand");
            if ($urandom_range(0, 999) == 0) asyncReset("randreset");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
